// File: rtl/tenthirty_nplayer_if.sv
`default_nettype none
// ============================================================================
// Module      : tenthirty_nplayer_if
// Description : Card request/valid handshake between the game engine and the
//               external deck block.
// Revision    : 1.0 - initial release
// ============================================================================
interface tenthirty_nplayer_if;
    logic       card_req;
    logic       card_vld;
    logic [3:0] card_val;

    // Engine side requests cards; deck side answers with a ranked card.
    modport master (
        output card_req,
        input  card_vld,
        input  card_val
    );

    modport slave (
        input  card_req,
        output card_vld,
        output card_val
    );
endinterface
`default_nettype wire

// File: rtl/tenthirty_nplayer.sv
`default_nettype none
// ============================================================================
// Module      : tenthirty_nplayer
// Description : Ten-and-a-half game engine, up to four players against an
//               automatic dealer; scores are kept in half-point units.
// Revision    : 1.0 - initial release
// ============================================================================
module tenthirty_nplayer #(
    parameter int NUM_PLAYERS  = 2,
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 14,
    parameter int PW           = $clog2(NUM_PLAYERS + 1)
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           btn_m,
    input  wire logic                           btn_r,
    tenthirty_nplayer_if.master                 deck,
    output logic [PW-1:0]                       cur_player,
    output logic [2:0]                          cur_cnt,
    output logic [6*(NUM_PLAYERS+1)-1:0]        scores,
    output logic [NUM_PLAYERS-1:0]              win,
    output logic [NUM_PLAYERS:0]                bust,
    output logic                                round_done
);

    localparam int            c_hands    = NUM_PLAYERS + 1;
    localparam logic [PW-1:0] c_dealer   = PW'(NUM_PLAYERS);
    localparam logic [2:0]    c_max_cnt  = 3'(MAX_CARDS);
    localparam logic [5:0]    c_stand    = 6'(DEALER_STAND);
    localparam logic [5:0]    c_limit    = 6'd21;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ADD     = 3'd2,
        S_TURN    = 3'd3,
        S_DEALER  = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic                   card_req_q, card_req_d;
    logic [PW-1:0]          cur_player_q, cur_player_d;
    logic [2:0]             cur_cnt_q, cur_cnt_d;
    logic [5:0]             score_q [c_hands];
    logic [5:0]             score_d [c_hands];
    logic [NUM_PLAYERS-1:0] win_q, win_d;
    logic [NUM_PLAYERS-1:0] auto_q, auto_d;
    logic [NUM_PLAYERS:0]   bust_q, bust_d;
    logic                   round_done_q, round_done_d;
    logic                   btn_m_prev_q, btn_m_prev_d;
    logic                   btn_r_prev_q, btn_r_prev_d;
    logic [3:0]             rank_q, rank_d;
    logic                   add_phase_q, add_phase_d;

    logic                   w_press_m;
    logic                   w_press_r;
    logic                   w_xfer;
    logic                   w_is_dealer;
    logic [5:0]             w_card_value;
    logic [5:0]             w_cur_score;

    assign w_press_m    = btn_m & ~btn_m_prev_q;
    assign w_press_r    = btn_r & ~btn_r_prev_q;
    assign w_xfer       = card_req_q & deck.card_vld;
    assign w_is_dealer  = (cur_player_q == c_dealer);
    assign w_cur_score  = score_q[cur_player_q];
    // Number cards are worth their rank in points; everything else is half a point.
    assign w_card_value = (rank_q >= 4'd1 && rank_q <= 4'd10) ? {1'b0, rank_q, 1'b0} : 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            card_req_q   <= 1'b0;
            cur_player_q <= '0;
            cur_cnt_q    <= '0;
            for (int i = 0; i < c_hands; i++) begin
                score_q[i] <= '0;
            end
            win_q        <= '0;
            auto_q       <= '0;
            bust_q       <= '0;
            round_done_q <= 1'b0;
            btn_m_prev_q <= 1'b0;
            btn_r_prev_q <= 1'b0;
            rank_q       <= '0;
            add_phase_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            card_req_q   <= card_req_d;
            cur_player_q <= cur_player_d;
            cur_cnt_q    <= cur_cnt_d;
            score_q      <= score_d;
            win_q        <= win_d;
            auto_q       <= auto_d;
            bust_q       <= bust_d;
            round_done_q <= round_done_d;
            btn_m_prev_q <= btn_m_prev_d;
            btn_r_prev_q <= btn_r_prev_d;
            rank_q       <= rank_d;
            add_phase_q  <= add_phase_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_player_d = cur_player_q;
        cur_cnt_d    = cur_cnt_q;
        score_d      = score_q;
        win_d        = win_q;
        auto_d       = auto_q;
        bust_d       = bust_q;
        rank_d       = rank_q;
        add_phase_d  = 1'b0;
        btn_m_prev_d = btn_m;
        btn_r_prev_d = btn_r;

        case (state_q)
            S_IDLE: begin
                if (w_press_m) begin
                    for (int i = 0; i < c_hands; i++) begin
                        score_d[i] = '0;
                    end
                    cur_player_d = '0;
                    cur_cnt_d    = '0;
                    win_d        = '0;
                    auto_d       = '0;
                    bust_d       = '0;
                    state_d      = S_FETCH;
                end
            end

            S_FETCH: begin
                if (w_xfer) begin
                    rank_d  = deck.card_val;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                if (!add_phase_q) begin
                    // First cycle accumulates; the second judges the registered totals.
                    score_d[cur_player_q] = w_cur_score + w_card_value;
                    cur_cnt_d             = cur_cnt_q + 3'd1;
                    add_phase_d           = 1'b1;
                end else if (w_cur_score > c_limit || cur_cnt_q == c_max_cnt || w_cur_score == c_limit) begin
                    for (int i = 0; i < c_hands; i++) begin
                        if (cur_player_q == PW'(i) && w_cur_score > c_limit) begin
                            bust_d[i] = 1'b1;
                        end
                    end
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (cur_player_q == PW'(i) && w_cur_score <= c_limit && cur_cnt_q == c_max_cnt) begin
                            auto_d[i] = 1'b1;
                        end
                    end
                    if (w_is_dealer) begin
                        state_d = S_COMPARE;
                    end else begin
                        cur_player_d = cur_player_q + 1'b1;
                        cur_cnt_d    = '0;
                        state_d      = S_FETCH;
                    end
                end else if (!w_is_dealer) begin
                    state_d = (cur_cnt_q == 3'd1) ? S_FETCH : S_TURN;
                end else begin
                    state_d = S_DEALER;
                end
            end

            S_TURN: begin
                // A press of both buttons together is a stand.
                if (w_press_r) begin
                    cur_player_d = cur_player_q + 1'b1;
                    cur_cnt_d    = '0;
                    state_d      = S_FETCH;
                end else if (w_press_m) begin
                    state_d = S_FETCH;
                end
            end

            S_DEALER: begin
                state_d = (w_cur_score < c_stand) ? S_FETCH : S_COMPARE;
            end

            S_COMPARE: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    win_d[i] = auto_q[i] |
                               (~bust_q[i] & (bust_q[NUM_PLAYERS] | (score_q[i] > score_q[NUM_PLAYERS])));
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (w_press_m) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        card_req_d   = (state_q == S_FETCH) && !w_xfer;
        round_done_d = (state_d == S_DONE);
    end

    assign deck.card_req = card_req_q;
    assign cur_player    = cur_player_q;
    assign cur_cnt       = cur_cnt_q;
    assign win           = win_q;
    assign bust          = bust_q;
    assign round_done    = round_done_q;

    generate
        for (genvar g = 0; g < c_hands; g++) begin : g_scores
            assign scores[6*g +: 6] = score_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tenthirty_nplayer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tenthirty_nplayer
// Description : Self-checking bench; plays scripted and random rounds against
//               a hand-level model of the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tenthirty_nplayer;
    localparam int NP = 2;
    localparam int NH = NP + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_m;
    logic        btn_r;
    logic [1:0]  cur_player;
    logic [2:0]  cur_cnt;
    logic [17:0] scores;
    logic [1:0]  win;
    logic [2:0]  bust;
    logic        round_done;

    tenthirty_nplayer_if deck();

    tenthirty_nplayer #(
        .NUM_PLAYERS (NP),
        .MAX_CARDS   (5),
        .DEALER_STAND(14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_m     (btn_m),
        .btn_r     (btn_r),
        .deck      (deck),
        .cur_player(cur_player),
        .cur_cnt   (cur_cnt),
        .scores    (scores),
        .win       (win),
        .bust      (bust),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit g_hold   = 1'b0;

    int m_score [NH];
    int m_cnt   [NH];
    bit m_bust  [NH];
    bit m_auto  [NP];
    int m_cur;
    int m_phase;       // 0 needs a card, 1 player deciding, 2 round over

    int q_cards[$];
    int q_dec[$];      // 0 hit, 1 stand, 2 both buttons

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int cv(input int r);
        return (r >= 1 && r <= 10) ? 2 * r : 1;
    endfunction

    function automatic void model_advance();
        if (m_cur == NP) m_phase = 2;
        else begin
            m_cur++;
            m_phase = 0;
        end
    endfunction

    function automatic void model_card(input int r);
        m_score[m_cur] += cv(r);
        m_cnt[m_cur]++;
        if (m_score[m_cur] > 21) begin
            m_bust[m_cur] = 1'b1;
            model_advance();
        end else if (m_cnt[m_cur] == 5) begin
            if (m_cur < NP) m_auto[m_cur] = 1'b1;
            model_advance();
        end else if (m_score[m_cur] == 21) begin
            model_advance();
        end else if (m_cur < NP) begin
            m_phase = (m_cnt[m_cur] == 1) ? 0 : 1;
        end else begin
            m_phase = (m_score[m_cur] < 14) ? 0 : 2;
        end
    endfunction

    function automatic logic [17:0] m_scores_packed();
        logic [17:0] p;
        int s;
        p = '0;
        for (int i = 0; i < NH; i++) begin
            s = m_score[i];
            p[6*i +: 6] = s[5:0];
        end
        return p;
    endfunction

    function automatic logic [1:0] m_win_vec();
        logic [1:0] w;
        w = '0;
        for (int i = 0; i < NP; i++) begin
            w[i] = m_auto[i] || (!m_bust[i] && (m_bust[NP] || m_score[i] > m_score[NP]));
        end
        return w;
    endfunction

    function automatic logic [2:0] m_bust_vec();
        logic [2:0] b;
        for (int i = 0; i < NH; i++) b[i] = m_bust[i];
        return b;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (g_hold) chk("stray_xfer", {63'd0, deck.card_req & deck.card_vld}, 64'd0);
    endtask

    task automatic press(input bit m, input bit r);
        btn_m = m;
        btn_r = r;
        tick();
        btn_m = 1'b0;
        btn_r = 1'b0;
    endtask

    task automatic get_card(input int v);
        int t;
        bit got;
        int junk;
        logic [3:0] vv;
        t   = 0;
        got = 1'b0;
        vv  = v[3:0];
        while (!got && t < 100) begin
            deck.card_vld = g_hold ? 1'b1 : 1'($urandom_range(0, 1));
            junk = $urandom_range(0, 15);
            deck.card_val = deck.card_vld ? vv : junk[3:0];
            got = deck.card_req && deck.card_vld;
            @(negedge clk);
            t++;
        end
        chk("xfer_timeout", {63'd0, got}, 64'd1);
        if (!g_hold) deck.card_vld = 1'b0;
    endtask

    task automatic play_round(input bit scripted);
        int steps;
        int c0;
        int r;
        int d;
        int t;
        for (int i = 0; i < NH; i++) begin
            m_score[i] = 0;
            m_cnt[i]   = 0;
            m_bust[i]  = 1'b0;
        end
        for (int i = 0; i < NP; i++) m_auto[i] = 1'b0;
        m_cur   = 0;
        m_phase = 0;
        steps   = 0;

        press(1'b1, 1'b0);
        chk("start_clear", {35'd0, scores, win, bust, cur_cnt, cur_player}, 64'd0);

        while (m_phase != 2 && steps < 64) begin
            steps++;
            if (m_phase == 0) begin
                if (scripted) r = (q_cards.size() != 0) ? q_cards.pop_front() : 2;
                else          r = $urandom_range(0, 15);
                c0 = m_cur;
                get_card(r);
                model_card(r);
                tick();
                chk("add_score", {58'd0, scores[6*c0 +: 6]}, 64'(m_score[c0]));
                chk("add_cnt", {61'd0, cur_cnt}, 64'(m_cnt[c0]));
                chk("add_player", {62'd0, cur_player}, 64'(c0));
                tick();
            end else begin
                tick();
                tick();
                chk("turn_wait", {63'd0, deck.card_req}, 64'd0);
                if (scripted) d = (q_dec.size() != 0) ? q_dec.pop_front() : 1;
                else          d = $urandom_range(0, 2);
                press(d == 0 || d == 2, d != 0);
                if (d == 0) m_phase = 0;
                else        model_advance();
            end
        end

        t = 0;
        while (!round_done && t < 40) begin
            tick();
            t++;
        end
        chk("done_timeout", {63'd0, round_done}, 64'd1);
        chk("win", {62'd0, win}, {62'd0, m_win_vec()});
        chk("bust", {61'd0, bust}, {61'd0, m_bust_vec()});
        chk("scores", {46'd0, scores}, {46'd0, m_scores_packed()});
    endtask

    task automatic leave_done();
        press(1'b1, 1'b0);
        chk("done_exit", {63'd0, round_done}, 64'd0);
        tick();
        tick();
        tick();
        chk("idle_no_restart", {63'd0, deck.card_req}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst           = 1'b1;
        btn_m         = 1'b0;
        btn_r         = 1'b0;
        deck.card_vld = 1'b0;
        deck.card_val = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {34'd0, deck.card_req, scores, win, bust, cur_cnt, cur_player, round_done}, 64'd0);
        rst = 1'b0;

        // Reset while the engine is waiting on the deck.
        press(1'b1, 1'b0);
        t = 0;
        while (!deck.card_req && t < 10) begin
            tick();
            t++;
        end
        chk("req_before_rst", {63'd0, deck.card_req}, 64'd1);
        rst           = 1'b1;
        deck.card_vld = 1'b1;
        deck.card_val = 4'd9;
        @(negedge clk);
        chk("mid_fetch_rst", {34'd0, deck.card_req, scores, win, bust, cur_cnt, cur_player, round_done}, 64'd0);
        rst           = 1'b0;
        deck.card_vld = 1'b0;
        tick();
        tick();
        chk("rst_stays_idle", {63'd0, deck.card_req}, 64'd0);

        // Tie goes to the dealer.
        q_cards = '{3, 4, 13, 13, 5, 2};
        q_dec   = '{1, 1};
        play_round(1'b1);
        chk("r1_scores", {46'd0, scores}, {46'd0, 6'd14, 6'd2, 6'd14});
        chk("r1_win", {62'd0, win}, 64'd0);
        leave_done();

        // Five-card auto-win beats a dealer 21; P1 busts without a press.
        q_cards = '{1, 11, 12, 13, 1, 10, 1, 11, 10};
        q_dec   = '{0, 0, 0};
        play_round(1'b1);
        chk("r2_scores", {46'd0, scores}, {46'd0, 6'd21, 6'd22, 6'd7});
        chk("r2_win", {62'd0, win}, 64'd1);
        chk("r2_bust", {61'd0, bust}, 64'd2);
        leave_done();

        // Dealer busts; every standing player wins.
        q_cards = '{3, 4, 10, 11, 2, 2, 2, 9};
        q_dec   = '{1};
        play_round(1'b1);
        chk("r3_scores", {46'd0, scores}, {46'd0, 6'd30, 6'd21, 6'd14});
        chk("r3_win", {62'd0, win}, 64'd3);
        chk("r3_bust", {61'd0, bust}, 64'd4);
        leave_done();

        // Deck valid held high; both buttons together act as stand.
        g_hold  = 1'b1;
        q_cards = '{3, 2, 5, 5, 2, 2, 2, 1};
        q_dec   = '{2, 2};
        play_round(1'b1);
        chk("r4_scores", {46'd0, scores}, {46'd0, 6'd14, 6'd20, 6'd10});
        chk("r4_win", {62'd0, win}, 64'd2);
        leave_done();
        g_hold        = 1'b0;
        deck.card_vld = 1'b0;

        for (int n = 0; n < 25; n++) begin
            g_hold = 1'($urandom_range(0, 1));
            play_round(1'b0);
            leave_done();
            g_hold        = 1'b0;
            deck.card_vld = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
